pipe_stage_skid_reg: RTL and testbench

Parametrised pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, ...). It replaces the bare enable/flush register with a valid/ready handshake backed by a 2-entry skid buffer, so a downstream stall never needs a combinational path to upstream. Flush squashes all held and presented beats and emits a bubble. A saturating counter records squashed beats for performance monitoring.

---
 rtl/pipe_stage_skid_reg.sv | 125 ++++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid
// buffer. in_ready depends only on registered state, so a downstream stall
// never reaches upstream through combinational logic. A flush squashes every
// held beat and any beat presented in the same cycle. A saturating counter
// records how many beats were squashed.
module pipe_stage_skid_reg #(
    parameter int                 DATA_W     = 64,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    // EMPTY: nothing held, ONE: main only, FULL: main and skid both held
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               main_valid;
    logic               in_fire;
    logic               out_fire;
    logic [1:0]         drop_add;
    logic [CNT_W:0]     cnt_sum;

    // The main entry is valid in every state but EMPTY; in_ready comes
    // straight from the state register
    always_comb begin
        main_valid = (state_q != ST_EMPTY);
        in_ready   = (state_q != ST_FULL);
        out_valid  = main_valid;
        out_data   = main_valid ? main_q : BUBBLE_VAL;
        in_fire    = in_valid & in_ready;
        out_fire   = main_valid & out_ready;
        drop_cnt   = cnt_q;
        case (state_q)
            ST_EMPTY: occupancy = 2'd0;
            ST_ONE:   occupancy = 2'd1;
            ST_FULL:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    // Beats lost to a flush: held entries not delivered this cycle plus the
    // beat accepted this cycle; the sum saturates instead of wrapping
    always_comb begin
        drop_add = occupancy - {1'b0, out_fire} + {1'b0, in_fire};
        cnt_sum  = {1'b0, cnt_q} + {{(CNT_W - 1){1'b0}}, drop_add};
    end

    // Next-state and datapath selection; flush overrides every transition
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
            cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // Upstream is stalled here, so only a drain can happen
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and data registers; reset dominates flush and clears the counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VAL;
            skid_q  <= BUBBLE_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg. A table of input/expected-output
// records drives the main instance; a second instance with a 2-bit counter
// exercises drop counter saturation.
module tb_pipe_stage_skid_reg;

    localparam int              DW     = 16;
    localparam logic [DW-1:0]   BUB    = 16'h0013;

    typedef struct packed {
        logic          rst;
        logic          fl;
        logic          iv;
        logic [DW-1:0] id;
        logic          orr;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
        logic [15:0]   e_cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic          reset_a, flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
    logic [DW-1:0] in_data_a, out_data_a;
    logic [1:0]    occ_a;
    logic [15:0]   cnt_a;

    // Saturation instance signals
    logic          reset_b, flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [DW-1:0] in_data_b, out_data_b;
    logic [1:0]    occ_b;
    logic [1:0]    cnt_b;

    pipe_stage_skid_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset_a), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .occupancy(occ_a), .drop_cnt(cnt_a)
    );

    pipe_stage_skid_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset_b), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .occupancy(occ_b), .drop_cnt(cnt_b)
    );

    int   n_total  = 0;
    int   n_passed = 0;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else
            n_passed++;
    endtask

    task automatic addv(input logic rst, input logic fl, input logic iv,
                        input logic [DW-1:0] id, input logic orr,
                        input logic e_ir, input logic e_ov, input logic [DW-1:0] e_od,
                        input logic [1:0] e_occ, input logic [15:0] e_cnt);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.orr = orr;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // One cycle on instance B, then check occupancy and drop count
    task automatic step_b(input string nm, input logic fl, input logic iv,
                          input logic [DW-1:0] id, input logic orr,
                          input logic [1:0] e_occ, input logic [1:0] e_cnt);
        flush_b = fl; in_valid_b = iv; in_data_b = id; out_ready_b = orr;
        @(posedge clk);
        #1;
        $display("B %s: occ=%0d cnt=%0d", nm, occ_b, cnt_b);
        chk({nm, ".occ"}, 64'(occ_b), 64'(e_occ));
        chk({nm, ".cnt"}, 64'(cnt_b), 64'(e_cnt));
    endtask

    initial begin
        reset_a = 1'b1; flush_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
        reset_b = 1'b1; flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;

        //   rst fl iv id       or | ir ov od       occ cnt
        // Reset with in_valid high: the beat is ignored
        addv(1, 0, 1, 16'h0077, 0,  1, 0, BUB,     0, 0);
        // Streaming 1..8 with out_ready=1: one cycle latency, occupancy 1
        for (int i = 1; i <= 8; i++)
            addv(0, 0, 1, DW'(i), 1,  1, 1, DW'(i), 1, 0);
        addv(0, 0, 0, 16'h0000, 1,  1, 0, BUB,     0, 0);
        // Fill to FULL with a stall, then drain in order
        addv(0, 0, 1, 16'h000A, 0,  1, 1, 16'h000A, 1, 0);
        addv(0, 0, 1, 16'h000B, 0,  0, 1, 16'h000A, 2, 0);
        addv(0, 0, 1, 16'h00FF, 0,  0, 1, 16'h000A, 2, 0);  // offered while full: not taken
        addv(0, 0, 0, 16'h0000, 1,  1, 1, 16'h000B, 1, 0);
        addv(0, 0, 0, 16'h0000, 1,  1, 0, BUB,     0, 0);
        // FULL then flush with in_valid=1 (in_ready=0): two beats dropped
        addv(0, 0, 1, 16'h000A, 0,  1, 1, 16'h000A, 1, 0);
        addv(0, 0, 1, 16'h000B, 0,  0, 1, 16'h000A, 2, 0);
        addv(0, 1, 1, 16'h0055, 0,  1, 0, BUB,     0, 2);
        // ONE, flush while delivering and accepting: head delivered, new beat dropped
        addv(0, 0, 1, 16'h000C, 0,  1, 1, 16'h000C, 1, 2);
        addv(0, 1, 1, 16'h000D, 1,  1, 0, BUB,     0, 3);
        // Flush when empty and idle: no count change
        addv(0, 1, 0, 16'h0000, 0,  1, 0, BUB,     0, 3);
        // ONE, flush with nothing delivered: one drop
        addv(0, 0, 1, 16'h0021, 0,  1, 1, 16'h0021, 1, 3);
        addv(0, 1, 0, 16'h0000, 0,  1, 0, BUB,     0, 4);
        // Flush when empty with a beat offered: that beat is dropped
        addv(0, 1, 1, 16'h0031, 1,  1, 0, BUB,     0, 5);
        // FULL then reset together with flush: everything cleared, no counting
        addv(0, 0, 1, 16'h000A, 0,  1, 1, 16'h000A, 1, 5);
        addv(0, 0, 1, 16'h000B, 0,  0, 1, 16'h000A, 2, 5);
        addv(1, 1, 1, 16'h0066, 0,  1, 0, BUB,     0, 0);
        // Beat accepted right after reset appears one cycle later
        addv(0, 0, 1, 16'h000E, 0,  1, 1, 16'h000E, 1, 0);
        addv(0, 0, 0, 16'h0000, 1,  1, 0, BUB,     0, 0);

        // Bring instance B out of reset alongside the first vector
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset_a     = vecs[i].rst;
            flush_a     = vecs[i].fl;
            in_valid_a  = vecs[i].iv;
            in_data_a   = vecs[i].id;
            out_ready_a = vecs[i].orr;
            @(posedge clk);
            #1;
            reset_b = 1'b0;
            $display("A vec %0d: ir=%0b ov=%0b od=0x%0h occ=%0d cnt=%0d",
                     i, in_ready_a, out_valid_a, out_data_a, occ_a, cnt_a);
            chk($sformatf("v%0d.in_ready", i),  64'(in_ready_a),  64'(vecs[i].e_ir));
            chk($sformatf("v%0d.out_valid", i), 64'(out_valid_a), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d.out_data", i),  64'(out_data_a),  64'(vecs[i].e_od));
            chk($sformatf("v%0d.occupancy", i), 64'(occ_a),       64'(vecs[i].e_occ));
            chk($sformatf("v%0d.drop_cnt", i),  64'(cnt_a),       64'(vecs[i].e_cnt));
        end

        // Saturating 2-bit counter: repeated two-entry flushes give 2, 3, 3
        chk("b.reset_cnt", 64'(cnt_b), 64'(0));
        for (int r = 0; r < 3; r++) begin
            step_b($sformatf("r%0d.load1", r), 1'b0, 1'b1, DW'(16'h40 + r), 1'b0, 2'd1, (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3);
            step_b($sformatf("r%0d.load2", r), 1'b0, 1'b1, DW'(16'h50 + r), 1'b0, 2'd2, (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3);
            step_b($sformatf("r%0d.flush", r), 1'b1, 1'b0, DW'(0),          1'b0, 2'd0, (r == 0) ? 2'd2 : 2'd3);
        end
        chk("b.out_data_bubble", 64'(out_data_b), 64'(BUB));

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
